// File: rtl/pc_pkg.sv
// Shared definitions for the programmable counter: action encoding and
// return-stack sizing helpers.
package pc_pkg;

  typedef enum logic [2:0] {
    HOLD,
    COUNT,
    LOAD,
    CALL,
    RET
  } pc_action_e;

  // Pointer must represent 0..depth inclusive so "full" is a distinct value.
  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for prog_counter with registered full/empty status.
// Contents are not reset; clearing the pointer discards them.
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = idx_width(DEPTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0]    sp_d, sp_q;
  logic [WIDTH-1:0] mem_d [2**IW];
  logic [WIDTH-1:0] mem_q [2**IW];
  logic             full_d, full_q, empty_d, empty_q;
  logic [IW-1:0]    wr_idx, rd_idx;

  always_comb begin
    wr_idx  = IW'(sp_q);
    rd_idx  = IW'(sp_q - 1'b1);
    mem_d   = mem_q;
    sp_d    = sp_q;
    if (push) begin
      mem_d[wr_idx] = push_data;
      sp_d          = sp_q + 1'b1;
    end else if (pop) begin
      sp_d = sp_q - 1'b1;
    end
    full_d  = (sp_d == DEPTH_P);
    empty_d = (sp_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top_data = mem_q[rd_idx];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/prog_counter.sv
// Modulo up/down program counter with jump, call/return and sticky error.
// Return stack is present only when PROG_COUNTER_STACK_EN is defined.
module prog_counter
  import pc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MODULO      = 256,
  parameter int SATURATE    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             wrap,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  pc_action_e       action;
  logic [WIDTH-1:0] value_d, value_q, ret_addr, top_data;
  logic             wrap_d, wrap_q, err_d, err_q;
  logic             push, pop, full, empty, target_bad, at_end;

`ifdef PROG_COUNTER_STACK_EN
  localparam bit HAS_STACK = 1'b1;

  pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top_data  (top_data),
    .full      (full),
    .empty     (empty)
  );
`else
  localparam bit HAS_STACK = 1'b0;
  localparam int unused_depth = STACK_DEPTH;
  logic unused_stack;

  assign unused_stack = ^{push, pop, ret_addr};
  assign top_data     = '0;
  assign full         = 1'b0;
  assign empty        = 1'b1;
`endif

  always_comb begin
    action = HOLD;
    if (load) begin
      action = LOAD;
    end else if (call) begin
      action = HAS_STACK ? CALL : LOAD;
    end else if (ret && HAS_STACK) begin
      action = RET;
    end else if (en) begin
      action = COUNT;
    end
  end

  // A count at the range end either wraps (pulsing wrap) or saturates.
  always_comb begin
    target_bad = ({1'b0, load_value} >= MOD_EXT);
    at_end     = up ? (value_q == MAX_VAL) : (value_q == '0);
    ret_addr   = (value_q == MAX_VAL) ? '0 : value_q + 1'b1;
    value_d    = value_q;
    wrap_d     = 1'b0;
    err_d      = err_q;
    push       = 1'b0;
    pop        = 1'b0;
    case (action)
      LOAD, CALL: begin
        value_d = target_bad ? '0 : load_value;
        if (target_bad) err_d = 1'b1;
        if (action == CALL) begin
          if (full) err_d = 1'b1;
          else push = 1'b1;
        end
      end
      RET: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          pop     = 1'b1;
          value_d = top_data;
        end
      end
      COUNT: begin
        if (at_end) begin
          if (SATURATE == 0) begin
            value_d = up ? '0 : MAX_VAL;
            wrap_d  = 1'b1;
          end
        end else begin
          value_d = up ? value_q + 1'b1 : value_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign value       = value_q;
  assign tc          = en && at_end;
  assign wrap        = wrap_q;
  assign err         = err_q;
  assign stack_full  = full;
  assign stack_empty = empty;

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits.
REQ-002 SHALL have parameter MODULO, default 256: count range 0..MODULO-1; legal 2..2**WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 1 = hold at range end instead of wrapping.
REQ-004 SHALL have parameter STACK_DEPTH, default 4: return-stack entries; legal 1..16.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1: enables increment/decrement.
REQ-008 SHALL have port up, input, 1: 1 = count up, 0 = count down.
REQ-009 SHALL have port load, input, 1: jump; value takes load_value.
REQ-010 SHALL have port load_value, input, WIDTH: jump/call target.
REQ-011 SHALL have port call, input, 1: push return address, then jump.
REQ-012 SHALL have port ret, input, 1: pop return address into value.
REQ-013 SHALL have port value, output, WIDTH: registered count.
REQ-014 SHALL have port tc, output, 1: combinational terminal count.
REQ-015 SHALL have port wrap, output, 1: registered one-cycle wrap pulse.
REQ-016 SHALL have ports stack_full and stack_empty, output, 1 each: registered stack status.
REQ-017 SHALL have port err, output, 1: sticky error flag.

Function
REQ-018 SHALL apply exactly one action per clk edge, priority: load > call > ret > count (en) > hold.
REQ-019 SHALL, on load or call, set value to load_value; if load_value >= MODULO, SHALL instead set value to 0 and set err.
REQ-020 SHALL, on call, push (value+1) mod MODULO; when stack_full, jump still occurs, push is discarded, err is set.
REQ-021 SHALL, on ret, set value to popped entry; when stack_empty, value holds and err is set.
REQ-022 SHALL, on count with up=1, increment value; at MODULO-1, value becomes 0 (wrap=1 next cycle), or holds if SATURATE=1.
REQ-023 SHALL, on count with up=0, decrement value; at 0, value becomes MODULO-1 (wrap=1 next cycle), or holds if SATURATE=1.
REQ-024 SHALL drive tc=1 when en=1 and value is MODULO-1 (up=1) or 0 (up=0), independent of SATURATE.
REQ-025 SHALL pulse wrap for exactly one cycle per wrap; load, call and ret never assert wrap.
REQ-026 SHALL keep err set until reset; err never self-clears.
REQ-027 SHALL produce all next-state results in one cycle (latency 1 edge).

Reset
REQ-028 SHALL, while reset=0, asynchronously force value=0, wrap=0, err=0, stack_empty=1, stack_full=0, stack pointer=0.
REQ-029 SHALL discard stack contents on reset; reset mid-call or mid-ret leaves no partial push/pop.
REQ-030 SHALL begin acting on the first rising clk edge after reset deasserts.

Configuration
REQ-031 SHALL implement the return stack only when macro PROG_COUNTER_STACK_EN is defined.
REQ-032 SHALL, without PROG_COUNTER_STACK_EN, treat call as load, ignore ret (no err), and tie stack_full=0 and stack_empty=1.

Structure
REQ-033 SHALL take the action encoding (enum: HOLD, COUNT, LOAD, CALL, RET) and the stack-pointer width function from shared package pc_pkg.
REQ-034 SHALL place the LIFO storage, pointer, and full/empty logic in sub-module pc_stack, instantiated only under PROG_COUNTER_STACK_EN.

Verification (WIDTH=8, MODULO=10, STACK_DEPTH=2 unless noted)
REQ-035 SHALL cover: en=1, up=1 from reset for 10 cycles -> value 0..9 then 0; wrap high one cycle after 9->0; tc high at 9.
REQ-036 SHALL cover: SATURATE=1, up=0 from 0 -> value holds at 0, wrap never asserts, tc=1.
REQ-037 SHALL cover: value=3, call to 7; call to 2; ret; ret -> value 7, 2, 8, 4; stack_full after second call; stack_empty at end.
REQ-038 SHALL cover: third call with stack full -> jump taken, err=1; ret with empty stack -> value holds, err stays 1.
REQ-039 SHALL cover: load_value=12 -> value=0, err=1; load and call and en in the same cycle -> load only, stack unchanged.
REQ-040 SHALL cover: reset asserted mid-count at value 5, between edges -> value=0 immediately, no clk edge needed; stack_empty=1.
